// File: rtl/axi_llc_sram_sched.sv
// Shares one single-port LLC SRAM between NumReq round-robin requesters, routes read
// responses back through a latency-matched tag pipe, schedules ECC scrubs and counts errors.
module axi_llc_sram_sched #(
  parameter int NumReq        = 2,
  parameter int AddrWidth     = 10,
  parameter int DataWidth     = 128,
  parameter int BeWidth       = 16,
  parameter int NumBanks      = 1,
  parameter int RespLatency   = 1,
  parameter int ScrubInterval = 1024,
  parameter int MaxDefer      = 64,
  parameter int CntWidth      = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_i,
  input  logic [NumReq-1:0]           we_i,
  input  logic [NumReq*AddrWidth-1:0] addr_i,
  input  logic [NumReq*DataWidth-1:0] wdata_i,
  input  logic [NumReq*BeWidth-1:0]   be_i,
  output logic [NumReq-1:0]           gnt_o,
  output logic [NumReq-1:0]           rvalid_o,
  output logic [DataWidth-1:0]        rdata_o,
  output logic                        sram_req_o,
  output logic                        sram_we_o,
  output logic [AddrWidth-1:0]        sram_addr_o,
  output logic [DataWidth-1:0]        sram_wdata_o,
  output logic [BeWidth-1:0]          sram_be_o,
  input  logic                        sram_gnt_i,
  input  logic [DataWidth-1:0]        sram_rdata_i,
  output logic [NumBanks-1:0]         scrub_trigger_o,
  input  logic [NumBanks-1:0]         single_error_i,
  input  logic [NumBanks-1:0]         multi_error_i,
  input  logic [NumBanks-1:0]         scrub_fix_i,
  input  logic                        cnt_clear_i,
  output logic [CntWidth-1:0]         single_cnt_o,
  output logic [CntWidth-1:0]         multi_cnt_o,
  output logic [CntWidth-1:0]         fix_cnt_o
);

  localparam int IdxW      = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int TimerInit = (ScrubInterval > 0) ? ScrubInterval - 1 : 0;
  localparam int TimerW    = (TimerInit > 0) ? $clog2(TimerInit + 1) : 1;
  localparam int DeferW    = $clog2(MaxDefer + 1);
  localparam bit ScrubEn   = (ScrubInterval > 0);

  logic [IdxW-1:0] rr_ptr_reg, rr_ptr_next, winner;
  logic [IdxW:0]   cand;
  logic            found, any_req, block, handshake, winner_we;

  assign any_req = |req_i;

  // Rotating priority scan starting at the round-robin pointer.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = {1'b0, rr_ptr_reg} + (IdxW+1)'(k);
      if (cand >= (IdxW+1)'(NumReq)) cand = cand - (IdxW+1)'(NumReq);
      if (!found && req_i[cand[IdxW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IdxW-1:0];
      end
    end
  end

  assign winner_we    = we_i[winner];
  assign handshake    = any_req & ~block & sram_gnt_i;
  assign sram_req_o   = any_req & ~block;
  assign sram_we_o    = any_req & winner_we;
  assign sram_addr_o  = any_req ? addr_i[winner*AddrWidth +: AddrWidth] : '0;
  assign sram_wdata_o = any_req ? wdata_i[winner*DataWidth +: DataWidth] : '0;
  assign sram_be_o    = any_req ? be_i[winner*BeWidth +: BeWidth] : '0;

  always_comb begin
    gnt_o = '0;
    if (handshake) gnt_o[winner] = 1'b1;
  end

  assign rr_ptr_next = !handshake                     ? rr_ptr_reg :
                       (winner == IdxW'(NumReq - 1))  ? '0         :
                                                        winner + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_ptr_reg <= '0;
    else         rr_ptr_reg <= rr_ptr_next;
  end

  // Tag pipe matched to the SRAM read latency; writes enter as bubbles.
  logic            pipe_valid_reg [RespLatency];
  logic [IdxW-1:0] pipe_idx_reg   [RespLatency];

  genvar gi;
  generate
    for (gi = 0; gi < RespLatency; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            pipe_valid_reg[0] <= 1'b0;
            pipe_idx_reg[0]   <= '0;
          end else begin
            pipe_valid_reg[0] <= handshake & ~winner_we;
            pipe_idx_reg[0]   <= winner;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            pipe_valid_reg[gi] <= 1'b0;
            pipe_idx_reg[gi]   <= '0;
          end else begin
            pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
            pipe_idx_reg[gi]   <= pipe_idx_reg[gi-1];
          end
        end
      end
    end

    for (gi = 0; gi < NumReq; gi++) begin : g_rvalid
      assign rvalid_o[gi] = pipe_valid_reg[RespLatency-1] &&
                            (pipe_idx_reg[RespLatency-1] == IdxW'(gi));
    end
  endgenerate

  assign rdata_o = sram_rdata_i;

  // Scrub scheduling: a scrub is due once the timer expires; it takes an idle
  // cycle, or steals one by blocking the bus after MaxDefer busy cycles.
  logic [TimerW-1:0] timer_reg;
  logic [DeferW-1:0] defer_reg;
  logic              pending_reg, due, fire;

  assign due   = ScrubEn && (pending_reg || (timer_reg == '0));
  assign block = due && any_req && (defer_reg == DeferW'(MaxDefer - 1));
  assign fire  = due && (!any_req || block);
  assign scrub_trigger_o = {NumBanks{fire}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_reg   <= TimerW'(TimerInit);
      defer_reg   <= '0;
      pending_reg <= 1'b0;
    end else if (fire) begin
      timer_reg   <= TimerW'(TimerInit);
      defer_reg   <= '0;
      pending_reg <= 1'b0;
    end else if (due) begin
      defer_reg   <= defer_reg + 1'b1;
      pending_reg <= 1'b1;
    end else if (ScrubEn) begin
      timer_reg   <= timer_reg - 1'b1;
    end
  end

  // Saturating error counters: 0 = correctable, 1 = uncorrectable, 2 = scrub fix.
  logic [CntWidth-1:0] cnt_reg [3];
  logic [2:0]          cnt_inc;

  assign cnt_inc = {|scrub_fix_i, |multi_error_i, |single_error_i};

  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                              cnt_reg[gi] <= '0;
        else if (cnt_clear_i)                     cnt_reg[gi] <= '0;
        else if (cnt_inc[gi] && (cnt_reg[gi] != '1)) cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
      end
    end
  endgenerate

  assign single_cnt_o = cnt_reg[0];
  assign multi_cnt_o  = cnt_reg[1];
  assign fix_cnt_o    = cnt_reg[2];

endmodule
